mips_data_path: RTL and testbench

//  Single-cycle MIPS datapath: PC, 32x32 register file, sign-extend, ALU,

---
 rtl/mips_data_path.sv | 108 ++++++++++
 tb/tb_mips_data_path.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/mips_data_path.sv
// Single-cycle MIPS datapath: PC, 32x32 register file, sign-extend, ALU and
// branch/jump next-PC selection. Control bits come from an external controller.
module mips_data_path #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        RegDst,
   input  logic        MemtoReg,
   input  logic [31:0] Data_in,
   input  logic [25:0] inst_field,
   input  logic [2:0]  ALU_Control,
   input  logic        RegWrite,
   input  logic        Branch,
   input  logic        ALUSrc_B,
   input  logic        Jump,
   output logic [31:0] Data_out,
   output logic [31:0] PC_out,
   output logic [31:0] ALU_out
);

   localparam int unsigned DW   = 32;
   localparam int unsigned AW   = 5;
   localparam int unsigned NREG = 32;

   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_XOR = 3'b011;
   localparam logic [2:0] ALU_NOR = 3'b100;
   localparam logic [2:0] ALU_SRL = 3'b101;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_SLT = 3'b111;

   logic [DW-1:0] pc_q, pc_d;
   logic [DW-1:0] rf_q [NREG];

   logic [AW-1:0] rs, rt, rd, wr_addr;
   logic [15:0]   imm;
   logic [DW-1:0] sext, rs_data, rt_data, alu_b, alu_res, wr_data, pc4;
   logic          zero, wr_en;

   // Field decode and register-file read ports ($0 is hard-wired to zero)
   always_comb begin
      rs      = inst_field[25:21];
      rt      = inst_field[20:16];
      rd      = inst_field[15:11];
      imm     = inst_field[15:0];
      sext    = {{16{imm[15]}}, imm};
      rs_data = (rs == '0) ? '0 : rf_q[rs];
      rt_data = (rt == '0) ? '0 : rf_q[rt];
   end

   // ALU
   always_comb begin
      alu_b   = ALUSrc_B ? sext : rt_data;
      alu_res = '0;
      case (ALU_Control)
         ALU_AND: alu_res = rs_data & alu_b;
         ALU_OR:  alu_res = rs_data | alu_b;
         ALU_ADD: alu_res = rs_data + alu_b;
         ALU_XOR: alu_res = rs_data ^ alu_b;
         ALU_NOR: alu_res = ~(rs_data | alu_b);
         ALU_SRL: alu_res = rs_data >> alu_b[4:0];
         ALU_SUB: alu_res = rs_data - alu_b;
         ALU_SLT: alu_res = DW'(($signed(rs_data) < $signed(alu_b)) ? 1 : 0);
         default: alu_res = '0;
      endcase
      zero = (alu_res == '0);
   end

   // Write-back selection; writes to $0 are dropped here
   always_comb begin
      wr_addr = RegDst ? rd : rt;
      wr_data = MemtoReg ? Data_in : alu_res;
      wr_en   = RegWrite && (wr_addr != '0);
   end

   // Next PC: jump has priority over a taken branch
   always_comb begin
      pc4  = pc_q + DW'(4);
      pc_d = pc4;
      if (Jump) begin
         pc_d = {pc4[31:28], inst_field, 2'b00};
      end else if (Branch && zero) begin
         pc_d = pc4 + {sext[29:0], 2'b00};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q <= RESET_PC;
         for (int i = 0; i < NREG; i++) begin
            rf_q[i] <= '0;
         end
      end else begin
         pc_q <= pc_d;
         if (wr_en) begin
            rf_q[wr_addr] <= wr_data;
         end
      end
   end

   assign PC_out   = pc_q;
   assign ALU_out  = alu_res;
   assign Data_out = rt_data;

endmodule

// File: tb/tb_mips_data_path.sv
// Directed bench for mips_data_path with hand-computed expectations.
module tb_mips_data_path;

   logic        clk = 1'b0;
   logic        rst;
   logic        RegDst, MemtoReg, RegWrite, Branch, ALUSrc_B, Jump;
   logic [31:0] Data_in;
   logic [25:0] inst_field;
   logic [2:0]  ALU_Control;
   logic [31:0] Data_out, PC_out, ALU_out;

   int checks   = 0;
   int failures = 0;

   mips_data_path #(.RESET_PC(32'h0000_0000)) dut (
      .clk(clk), .rst(rst), .RegDst(RegDst), .MemtoReg(MemtoReg),
      .Data_in(Data_in), .inst_field(inst_field), .ALU_Control(ALU_Control),
      .RegWrite(RegWrite), .Branch(Branch), .ALUSrc_B(ALUSrc_B), .Jump(Jump),
      .Data_out(Data_out), .PC_out(PC_out), .ALU_out(ALU_out)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got=%08h expected=%08h", tag, got, exp);
      end
   endtask

   // Advance one rising edge, then settle away from it
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [25:0] itype(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [15:0] imm);
      return {rs, rt, imm};
   endfunction

   function automatic logic [25:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd);
      return {rs, rt, rd, 11'd0};
   endfunction

   task automatic idle();
      RegDst = 0; MemtoReg = 0; RegWrite = 0; Branch = 0; ALUSrc_B = 0; Jump = 0;
      Data_in = '0; inst_field = '0; ALU_Control = 3'b010;
   endtask

   logic [2:0]  ops [7]  = '{3'b000, 3'b001, 3'b011, 3'b100, 3'b110, 3'b101, 3'b010};
   logic [31:0] exps [7] = '{32'h0000_0005, 32'hDEAD_BEEF, 32'hDEAD_BEEA, 32'h2152_4110,
                             32'hDEAD_BEEA, 32'h06F5_6DF7, 32'hDEAD_BEF4};

   initial begin
      idle();
      rst = 1;
      #1;
      // 1: reset
      step();
      step();
      check("reset_pc", PC_out, 32'h0);
      check("reset_alu_add0", ALU_out, 32'h0);
      inst_field = itype(5'd0, 5'd7, 16'd0);
      #1 check("reset_reg7", Data_out, 32'h0);
      inst_field = '0;

      // 2: sequential PC
      rst = 0;
      step(); check("seq_pc4", PC_out, 32'd4);
      step(); check("seq_pc8", PC_out, 32'd8);
      step(); check("seq_pc12", PC_out, 32'd12);

      // 3: ADDI $1 = $0 + 5, then attempt $0 = 5
      inst_field = itype(5'd0, 5'd1, 16'd5);
      ALUSrc_B = 1; RegWrite = 1;
      #1 check("addi_alu", ALU_out, 32'd5);
      check("addi_nobypass", Data_out, 32'd0);
      step();
      check("addi_pc", PC_out, 32'd16);
      RegWrite = 0;
      #1 check("addi_r1", Data_out, 32'd5);
      inst_field = itype(5'd0, 5'd0, 16'd5);
      RegWrite = 1;
      step();
      RegWrite = 0;
      #1 check("addi_r0_stays0", Data_out, 32'd0);

      // 4: load $2 = DEADBEEF, then SLT and the other ALU ops with A=$2, B=$1
      inst_field = itype(5'd0, 5'd2, 16'd0);
      MemtoReg = 1; Data_in = 32'hDEAD_BEEF; RegWrite = 1;
      step();
      MemtoReg = 0; RegWrite = 0; ALUSrc_B = 0;
      inst_field = itype(5'd2, 5'd1, 16'd0);
      ALU_Control = 3'b111;
      #1 check("slt_neg_lt_pos", ALU_out, 32'd1);
      check("load_rt1", Data_out, 32'd5);
      inst_field = itype(5'd1, 5'd2, 16'd0);
      #1 check("slt_pos_lt_neg", ALU_out, 32'd0);
      check("load_r2", Data_out, 32'hDEAD_BEEF);
      inst_field = itype(5'd2, 5'd1, 16'd0);
      for (int i = 0; i < 7; i++) begin
         ALU_Control = ops[i];
         #1 check($sformatf("alu_op%0d", ops[i]), ALU_out, exps[i]);
      end
      // R-type with RegDst: $3 = $1 + $1
      inst_field = rtype(5'd1, 5'd1, 5'd3);
      ALU_Control = 3'b010; RegDst = 1; RegWrite = 1;
      step();
      RegDst = 0; RegWrite = 0;
      inst_field = itype(5'd0, 5'd3, 16'd0);
      #1 check("regdst_r3", Data_out, 32'd10);

      // 5: branches from PC=8 (reached by jumping to target 2)
      Jump = 1; inst_field = 26'd2;
      step();
      Jump = 0;
      check("jump_to8", PC_out, 32'd8);
      Branch = 1; ALU_Control = 3'b110; ALUSrc_B = 0;
      inst_field = itype(5'd1, 5'd1, 16'hFFFF);
      #1 check("beq_zero", ALU_out, 32'd0);
      step(); check("beq_back", PC_out, 32'd8);
      inst_field = itype(5'd1, 5'd1, 16'd2);
      step(); check("beq_fwd", PC_out, 32'd20);
      inst_field = itype(5'd1, 5'd2, 16'd2);
      step(); check("beq_not_taken", PC_out, 32'd24);

      // 6: jump has priority over a taken branch, then reset mid-run
      Branch = 0; Jump = 1; inst_field = 26'd2;
      step(); check("jump_to8b", PC_out, 32'd8);
      Branch = 1; inst_field = 26'h40;
      step(); check("jump_priority", PC_out, 32'h100);
      Branch = 0; Jump = 0;
      step(); check("post_jump_pc4", PC_out, 32'h104);
      rst = 1; RegWrite = 1; ALUSrc_B = 1; ALU_Control = 3'b010;
      inst_field = itype(5'd0, 5'd1, 16'd9);
      step();
      rst = 0; RegWrite = 0;
      check("midrun_reset_pc", PC_out, 32'h0);
      #1 check("midrun_reset_r1", Data_out, 32'h0);
      inst_field = itype(5'd0, 5'd2, 16'd0);
      #1 check("midrun_reset_r2", Data_out, 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
